dm_port_arbiter: RTL and testbench
==================================

Name: dm_port_arbiter

Overview:
- Shares the single data-memory port (address, write data, write enable, size control, combinational read data) between two requesters.
- Requester 1 is the pipeline M stage (CPU); requester 2 is an external loader/debug port using a valid/ready handshake.
- CPU has fixed priority. A starvation counter guarantees the external port a slot, and the arbiter stalls the CPU for that one cycle.
- External accesses are range- and alignment-checked; external reads return registered data one cycle after acceptance.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles the external port may be blocked by the CPU before it is forced through.
- DEPTH_WORDS, 4096: number of 32-bit words in the data memory. External word index addr[31:2] must be < DEPTH_WORDS.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  M-stage memory access valid this cycle.
- cpu_we  in  1  CPU access is a store.
- cpu_addr  in  32  CPU byte address.
- cpu_wdata  in  32  CPU store data.
- cpu_ctr  in  3  CPU size code (`dm_sw / `dm_sh / other = byte).
- cpu_stall  out  1  CPU access not serviced this cycle; pipeline must hold M stage.
- ext_valid  in  1  external request valid.
- ext_ready  out  1  external request accepted this cycle.
- ext_we  in  1  external store.
- ext_addr  in  32  external byte address.
- ext_wdata  in  32  external store data.
- ext_ctr  in  3  external size code, same encoding as cpu_ctr.
- ext_rvalid  out  1  one-cycle pulse: response for the previously accepted external access.
- ext_rdata  out  32  registered external read data.
- ext_err  out  1  valid with ext_rvalid: access was out of range or misaligned.
- mem_addr  out  32  to dm memaddr.
- mem_wdata  out  32  to dm dmi.
- mem_write  out  1  to dm memwrite.
- mem_ctr  out  3  to dm dmictr.
- mem_rdata  in  32  from dm read port (combinational).

Behaviour:
- Starvation counter `scnt`, 0..STARVE_LIMIT:
  - Increments at each posedge where cpu_req && ext_valid && the CPU is granted.
  - Clears when ext_valid=0 or when the external port is granted.
  - Saturates at STARVE_LIMIT.
- Grant (combinational from the current registers):
  - grant_ext = ext_valid && (!cpu_req || scnt==STARVE_LIMIT).
  - grant_cpu = cpu_req && !grant_ext.
- Handshake outputs:
  - ext_ready = grant_ext.
  - cpu_stall = cpu_req && grant_ext.
  - A transfer occurs when ext_valid && ext_ready. The external side must hold its request fields while ext_valid=1 && ext_ready=0.
- Memory mux:
  - grant_ext: mem_* come from ext_*.
  - Otherwise: mem_* come from cpu_*.
  - mem_write = grant_ext ? (ext_we && !ext_bad) : (grant_cpu && cpu_we).
  - With no request, mem_write=0.
- ext_bad (combinational), set by any of:
  - ext_addr[31:2] >= DEPTH_WORDS.
  - ext_ctr==`dm_sw && ext_addr[1:0]!=0.
  - ext_ctr==`dm_sh && ext_addr[0]!=0.
- CPU accesses are never checked or blocked by ext_bad.
- Response, registered at the posedge of each external transfer:
  - ext_rvalid<=1 the next cycle.
  - ext_err<=ext_bad.
  - ext_rdata<= mem_rdata for a good read, otherwise 0.
  - Stores also produce ext_rvalid, with ext_rdata=0.
  - Without a transfer, ext_rvalid<=0 and ext_err<=0; ext_rdata holds its value.
  - Back-to-back external transfers give back-to-back rvalid pulses.
- Reset (rst=0, asynchronous):
  - scnt=0, ext_rvalid=0, ext_err=0, ext_rdata=0.
  - Combinational outputs follow inputs; mem_write is forced to 0 while rst=0.
  - A response in flight at reset assertion is discarded.
- Simultaneous events:
  - cpu_req and ext_valid in the same cycle with scnt<STARVE_LIMIT: CPU wins.
  - Same, with scnt==STARVE_LIMIT: external wins, cpu_stall=1, scnt clears.
  - The stalled CPU access is serviced the following cycle unless rst intervenes.

Test Plan:
- Only cpu_req=1, cpu_we=1, addr 0x10, wdata 0xDEADBEEF, `dm_sw -> mem_write=1, mem_addr=0x10, cpu_stall=0, ext_ready=0 every cycle.
- ext_valid=1 read at 0x20 (mem holds 0x12345678), CPU idle -> ext_ready=1 in cycle 0; ext_rvalid=1, ext_rdata=0x12345678, ext_err=0 in cycle 1.
- cpu_req held 1 and ext_valid held 1, STARVE_LIMIT=4:
  - Cycles 0-3: CPU granted, ext_ready=0.
  - Cycle 4: ext_ready=1, cpu_stall=1.
  - Cycle 5: CPU granted, scnt=0.
- External sw to 0x4002 -> transfer accepted, mem_write=0, next cycle ext_rvalid=1, ext_err=1, ext_rdata=0. Repeat with address 0x4000 (word 4096) -> same error response.
- Read accepted, then rst driven 0 mid-cycle before the next edge -> ext_rvalid, ext_err and ext_rdata are 0 immediately; no response pulse after rst returns to 1.
- External sb to 0x7 (`dm_sb-class code), CPU idle -> mem_write=1, mem_ctr=ext_ctr, mem_addr=0x7, ext_err=0.

Source files
------------

// File: rtl/dm_port_arbiter_if.sv
// Bus bundle for the data-memory port arbiter: CPU M-stage requester,
// external valid/ready requester and the shared data-memory port.
`ifndef DM_SB
`define DM_SB 3'b000
`endif
`ifndef DM_SH
`define DM_SH 3'b001
`endif
`ifndef DM_SW
`define DM_SW 3'b010
`endif

interface dm_port_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [2:0]  cpu_ctr;
  logic        cpu_stall;

  logic        ext_valid;
  logic        ext_ready;
  logic        ext_we;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic [2:0]  ext_ctr;
  logic        ext_rvalid;
  logic [31:0] ext_rdata;
  logic        ext_err;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic [2:0]  mem_ctr;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_ctr,
    output cpu_stall,
    input  ext_valid, ext_we, ext_addr, ext_wdata, ext_ctr,
    output ext_ready, ext_rvalid, ext_rdata, ext_err,
    output mem_addr, mem_wdata, mem_write, mem_ctr,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_ctr,
    input  cpu_stall,
    output ext_valid, ext_we, ext_addr, ext_wdata, ext_ctr,
    input  ext_ready, ext_rvalid, ext_rdata, ext_err,
    input  mem_addr, mem_wdata, mem_write, mem_ctr,
    output mem_rdata
  );
endinterface

// File: rtl/dm_port_arbiter.sv
// Shares the data-memory port between the CPU M stage (fixed priority) and an
// external valid/ready port, with a starvation counter forcing external slots.
module dm_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned DEPTH_WORDS  = 4096
) (
  input  logic              clk,
  input  logic              rst,
  dm_port_arbiter_if.slave  bus
);

  localparam int unsigned   SCW     = $clog2(STARVE_LIMIT + 1);
  localparam logic [SCW-1:0] SLIM   = SCW'(STARVE_LIMIT);
  localparam logic [31:0]   DEPTH_W = 32'(DEPTH_WORDS);

  logic [SCW-1:0] scnt;
  logic [SCW-1:0] scnt_nxt;
  logic           grant_ext;
  logic           grant_cpu;
  logic           ext_bad;
  logic           ext_rd_ok;

  always_comb begin
    ext_bad = 1'b0;
    if ({2'b00, bus.ext_addr[31:2]} >= DEPTH_W)
      ext_bad = 1'b1;
    if (bus.ext_ctr == `DM_SW && bus.ext_addr[1:0] != 2'b00)
      ext_bad = 1'b1;
    if (bus.ext_ctr == `DM_SH && bus.ext_addr[0])
      ext_bad = 1'b1;
  end

  always_comb begin
    grant_ext = bus.ext_valid && (!bus.cpu_req || scnt == SLIM);
    grant_cpu = bus.cpu_req && !grant_ext;
    ext_rd_ok = !bus.ext_we && !ext_bad;
  end

  assign bus.ext_ready = grant_ext;
  assign bus.cpu_stall = bus.cpu_req && grant_ext;

  // Memory writes are suppressed during reset so nothing lands in the array.
  always_comb begin
    bus.mem_addr  = grant_ext ? bus.ext_addr  : bus.cpu_addr;
    bus.mem_wdata = grant_ext ? bus.ext_wdata : bus.cpu_wdata;
    bus.mem_ctr   = grant_ext ? bus.ext_ctr   : bus.cpu_ctr;
    bus.mem_write = 1'b0;
    if (rst)
      bus.mem_write = grant_ext ? (bus.ext_we && !ext_bad)
                                : (grant_cpu && bus.cpu_we);
  end

  always_comb begin
    scnt_nxt = scnt;
    if (!bus.ext_valid || grant_ext)
      scnt_nxt = '0;
    else if (grant_cpu && scnt != SLIM)
      scnt_nxt = scnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scnt           <= '0;
      bus.ext_rvalid <= 1'b0;
      bus.ext_err    <= 1'b0;
      bus.ext_rdata  <= '0;
    end else begin
      scnt <= scnt_nxt;
      if (grant_ext) begin
        bus.ext_rvalid <= 1'b1;
        bus.ext_err    <= ext_bad;
        bus.ext_rdata  <= ext_rd_ok ? bus.mem_rdata : '0;
      end else begin
        bus.ext_rvalid <= 1'b0;
        bus.ext_err    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Randomized plus directed bench for dm_port_arbiter against a cycle-level
// reference model of the arbitration and response rules.
`ifndef DM_SB
`define DM_SB 3'b000
`endif
`ifndef DM_SH
`define DM_SH 3'b001
`endif
`ifndef DM_SW
`define DM_SW 3'b010
`endif

module tb_dm_port_arbiter;

  localparam int unsigned LIMIT = 4;
  localparam int unsigned DEPTH = 4096;

  logic clk;
  logic rst;

  dm_port_arbiter_if bus ();

  dm_port_arbiter #(.STARVE_LIMIT(LIMIT), .DEPTH_WORDS(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [0:4095];
  assign bus.mem_rdata = mem[bus.mem_addr[13:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests;
  int unsigned n_fail;

  // reference model state
  int unsigned waited;
  logic        exp_rvalid;
  logic        exp_err;
  logic [31:0] exp_rdata;
  logic        last_ready;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    waited     = 0;
    exp_rvalid = 1'b0;
    exp_err    = 1'b0;
    exp_rdata  = '0;
    last_ready = 1'b0;
  endtask

  task automatic step(input logic cr, input logic cw, input logic [31:0] ca,
                      input logic [31:0] cwd, input logic [2:0] cc,
                      input logic ev, input logic ew, input logic [31:0] ea,
                      input logic [31:0] ewd, input logic [2:0] ec);
    logic gext, gcpu, bad, wr;
    int unsigned idx;
    @(negedge clk);
    chk("rvalid", 32'(bus.ext_rvalid), 32'(exp_rvalid));
    chk("err",    32'(bus.ext_err),    32'(exp_err));
    chk("rdata",  bus.ext_rdata,       exp_rdata);
    bus.cpu_req   = cr;  bus.cpu_we  = cw;  bus.cpu_addr  = ca;
    bus.cpu_wdata = cwd; bus.cpu_ctr = cc;
    bus.ext_valid = ev;  bus.ext_we  = ew;  bus.ext_addr  = ea;
    bus.ext_wdata = ewd; bus.ext_ctr = ec;
    #1;
    idx  = ea / 4;
    bad  = (idx >= DEPTH) || (ec == `DM_SW && (ea % 4) != 0) ||
           (ec == `DM_SH && (ea % 2) != 0);
    gext = ev && (!cr || waited == LIMIT);
    gcpu = cr && !gext;
    wr   = rst && (gext ? (ew && !bad) : (gcpu && cw));
    chk("ready",  32'(bus.ext_ready), 32'(gext));
    chk("stall",  32'(bus.cpu_stall), 32'(cr && gext));
    chk("maddr",  bus.mem_addr,       gext ? ea : ca);
    chk("mwdata", bus.mem_wdata,      gext ? ewd : cwd);
    chk("mctr",   32'(bus.mem_ctr),   32'(gext ? ec : cc));
    chk("mwrite", 32'(bus.mem_write), 32'(wr));
    last_ready = gext;
    if (rst) begin
      if (gext) begin
        exp_rvalid = 1'b1;
        exp_err    = bad;
        exp_rdata  = (!ew && !bad) ? mem[idx % 4096] : 32'h0;
      end else begin
        exp_rvalid = 1'b0;
        exp_err    = 1'b0;
      end
      if (!ev || gext) waited = 0;
      else if (waited < LIMIT) waited++;
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 32'h0, `DM_SW, 1'b0, 1'b0, 32'h0, 32'h0, `DM_SW);
  endtask

  logic        r_cr, r_cw, r_ev, r_ew;
  logic [31:0] r_ca, r_cwd, r_ea, r_ewd;
  logic [2:0]  r_cc, r_ec;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    mem[8] = 32'h12345678;
    model_reset();

    rst = 1'b0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0; bus.cpu_ctr = 0;
    bus.ext_valid = 0; bus.ext_we = 0; bus.ext_addr = 0; bus.ext_wdata = 0; bus.ext_ctr = 0;
    repeat (3) @(negedge clk);
    bus.cpu_req = 1; bus.cpu_we = 1;
    #1;
    chk("rst_rvalid", 32'(bus.ext_rvalid), 32'h0);
    chk("rst_rdata",  bus.ext_rdata,       32'h0);
    chk("rst_mwrite", 32'(bus.mem_write),  32'h0);
    bus.cpu_req = 0; bus.cpu_we = 0;
    rst = 1'b1;

    // CPU store only
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 32'h10, 32'hDEADBEEF, `DM_SW, 0, 0, 32'h0, 32'h0, `DM_SW);
      chk("cpu_st_write", 32'(bus.mem_write), 32'h1);
      chk("cpu_st_addr",  bus.mem_addr,       32'h10);
      chk("cpu_st_ready", 32'(bus.ext_ready), 32'h0);
    end

    // external read with CPU idle
    step(0, 0, 32'h0, 32'h0, `DM_SW, 1, 0, 32'h20, 32'h0, `DM_SW);
    chk("ext_rd_ready", 32'(bus.ext_ready), 32'h1);
    idle();
    chk("ext_rd_rvalid", 32'(bus.ext_rvalid), 32'h1);
    chk("ext_rd_data",   bus.ext_rdata,       32'h12345678);

    // starvation: CPU and external both held
    idle();
    for (int k = 0; k < 6; k++) begin
      step(1, 0, 32'h100, 32'h0, `DM_SW, 1, 0, 32'h24, 32'h0, `DM_SW);
      chk("starve_ready", 32'(bus.ext_ready), (k == 4) ? 32'h1 : 32'h0);
      chk("starve_stall", 32'(bus.cpu_stall), (k == 4) ? 32'h1 : 32'h0);
    end
    idle();

    // misaligned and out-of-range word stores
    step(0, 0, 32'h0, 32'h0, `DM_SW, 1, 1, 32'h4002, 32'h55, `DM_SW);
    chk("bad1_write", 32'(bus.mem_write), 32'h0);
    idle();
    chk("bad1_err",   32'(bus.ext_err),   32'h1);
    chk("bad1_rdata", bus.ext_rdata,      32'h0);
    step(0, 0, 32'h0, 32'h0, `DM_SW, 1, 1, 32'h4000, 32'h55, `DM_SW);
    chk("bad2_write", 32'(bus.mem_write), 32'h0);
    idle();
    chk("bad2_err",   32'(bus.ext_err),   32'h1);

    // byte store at odd address is legal
    step(0, 0, 32'h0, 32'h0, `DM_SW, 1, 1, 32'h7, 32'hAB, `DM_SB);
    chk("sb_write", 32'(bus.mem_write), 32'h1);
    chk("sb_addr",  bus.mem_addr,       32'h7);
    chk("sb_ctr",   32'(bus.mem_ctr),   32'(`DM_SB));
    idle();
    chk("sb_err",   32'(bus.ext_err),   32'h0);

    // reset with a response in flight
    step(0, 0, 32'h0, 32'h0, `DM_SW, 1, 0, 32'h20, 32'h0, `DM_SW);
    @(posedge clk);
    #2;
    chk("flight_rvalid", 32'(bus.ext_rvalid), 32'h1);
    bus.ext_valid = 0; bus.cpu_req = 1; bus.cpu_we = 1;
    rst = 1'b0;
    #1;
    chk("arst_rvalid", 32'(bus.ext_rvalid), 32'h0);
    chk("arst_err",    32'(bus.ext_err),    32'h0);
    chk("arst_rdata",  bus.ext_rdata,       32'h0);
    chk("arst_mwrite", 32'(bus.mem_write),  32'h0);
    model_reset();
    step(1, 1, 32'h30, 32'h1, `DM_SW, 0, 0, 32'h0, 32'h0, `DM_SW);
    rst = 1'b1;
    idle();
    idle();

    // randomized traffic honoring the external hold rule
    r_ev = 0; r_ew = 0; r_ea = 0; r_ewd = 0; r_ec = 0;
    for (int n = 0; n < 3000; n++) begin
      r_cr  = ($urandom_range(0, 99) < 60);
      r_cw  = $urandom_range(0, 1) == 1;
      r_ca  = $urandom;
      r_cwd = $urandom;
      r_cc  = 3'($urandom_range(0, 3));
      if (!(r_ev && !last_ready)) begin
        r_ev  = ($urandom_range(0, 99) < 55);
        r_ew  = $urandom_range(0, 1) == 1;
        r_ewd = $urandom;
        r_ec  = 3'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
          0:       r_ea = 32'($urandom_range(0, 16383));
          1:       r_ea = 32'h4000 + 32'($urandom_range(0, 15));
          2:       r_ea = $urandom;
          default: r_ea = 32'($urandom_range(0, 63));
        endcase
      end
      step(r_cr, r_cw, r_ca, r_cwd, r_cc, r_ev, r_ew, r_ea, r_ewd, r_ec);
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
